// File: rtl/nibble_src_arbiter_pkg.sv
// Shared definitions for the nibble source arbiter family.
//   state_t     : arbiter FSM encoding (IDLE=0, ASK=1, WAIT=2, DONE=3)
//   NIBBLE_W    : width of the shared parallel nibble
//   CAP_DLY_DEF : default capture delay after the ask strobe
//   DLY_W       : width of the capture-delay counter (covers 1..7)
package nibble_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ASK  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int NIBBLE_W    = 4;
    localparam int CAP_DLY_DEF = 1;
    localparam int DLY_W       = 3;

endpackage

// File: rtl/nibble_src_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req    : in,  N_REQ-bit request vector
//   rr_ptr : in,  index of the highest-priority requester this round
//   gnt    : out, one-hot grant (zero when req is zero)
// The first set request found scanning upward from rr_ptr, wrapping at
// N_REQ, wins.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt
);

    localparam int unsigned NU = N_REQ;

    int unsigned w_ptr;
    int unsigned w_best;
    int unsigned w_dist;

    // Each requester's distance from the pointer is its priority rank;
    // the smallest rank among active requesters is unique, so the
    // second pass yields exactly one grant bit.
    always_comb begin
        w_ptr  = 32'(rr_ptr);
        w_best = NU;
        w_dist = '0;
        gnt    = '0;
        for (int unsigned k = 0; k < NU; k++) begin
            if (req[k]) begin
                w_dist = (k + NU - w_ptr) % NU;
                if (w_dist < w_best) begin
                    w_best = w_dist;
                end
            end
        end
        for (int unsigned k = 0; k < NU; k++) begin
            if (req[k]) begin
                w_dist = (k + NU - w_ptr) % NU;
                if (w_dist == w_best) begin
                    gnt[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/nibble_src_arbiter.sv
// Round-robin arbiter sharing one parallel nibble source between
// N_REQ consumers.
//   sclk         : in,  system clock (rising edge)
//   rst          : in,  asynchronous active-low reset
//   req          : in,  per-consumer level request, sampled in IDLE
//   ask_for_data : out, one-cycle strobe to the nibble source
//   data         : in,  nibble from the source
//   gnt          : out, one-hot grant, held ASK..DONE
//   dout         : out, captured nibble, held until the next capture
//   dout_vld     : out, one-hot valid, equals gnt during DONE
//   busy         : out, high whenever not IDLE
//   served_cnt   : out, packed per-consumer completed-transaction counters
// Every output is a register, so req has no combinational path out.
module nibble_src_arbiter
    import nibble_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int CAP_DLY = CAP_DLY_DEF,
    parameter int CNT_W   = 8
) (
    input  logic                   sclk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    output logic                   ask_for_data,
    input  logic [NIBBLE_W-1:0]    data,
    output logic [N_REQ-1:0]       gnt,
    output logic [NIBBLE_W-1:0]    dout,
    output logic [N_REQ-1:0]       dout_vld,
    output logic                   busy,
    output logic [N_REQ*CNT_W-1:0] served_cnt
);

    localparam int          PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned NU    = N_REQ;

    state_t                       r_state;
    logic [N_REQ-1:0]             r_gnt;
    logic [PTR_W-1:0]             r_gidx;
    logic [PTR_W-1:0]             r_rr_ptr;
    logic [DLY_W-1:0]             r_cnt;
    logic                         r_ask;
    logic                         r_busy;
    logic [N_REQ-1:0]             r_vld;
    logic [NIBBLE_W-1:0]          r_dout;
    logic [N_REQ-1:0][CNT_W-1:0]  r_served;

    logic [N_REQ-1:0]             w_pick;
    logic [PTR_W-1:0]             w_pick_idx;
    logic [PTR_W-1:0]             w_next_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .gnt    (w_pick)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int unsigned k = 0; k < NU; k++) begin
            if (w_pick[k]) begin
                w_pick_idx = PTR_W'(k);
            end
        end
    end

    // The winner drops to lowest priority for the next round.
    assign w_next_ptr = (r_gidx == PTR_W'(N_REQ - 1)) ? '0 : r_gidx + PTR_W'(1);

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
            r_ask    <= 1'b0;
            r_busy   <= 1'b0;
            r_vld    <= '0;
            r_dout   <= '0;
            r_served <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_gnt   <= w_pick;
                        r_gidx  <= w_pick_idx;
                        r_ask   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_ASK;
                    end
                end
                ST_ASK: begin
                    r_ask   <= 1'b0;
                    r_cnt   <= DLY_W'(CAP_DLY);
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Capture on the edge that ends the last wait cycle;
                    // dout_vld is raised together so it is live in DONE.
                    if (r_cnt == DLY_W'(1)) begin
                        r_dout  <= data;
                        r_vld   <= r_gnt;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - DLY_W'(1);
                    end
                end
                ST_DONE: begin
                    r_vld            <= '0;
                    r_served[r_gidx] <= r_served[r_gidx] + CNT_W'(1);
                    r_rr_ptr         <= w_next_ptr;
                    r_gnt            <= '0;
                    r_busy           <= 1'b0;
                    r_state          <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ask_for_data = r_ask;
    assign gnt          = r_gnt;
    assign dout         = r_dout;
    assign dout_vld     = r_vld;
    assign busy         = r_busy;
    assign served_cnt   = r_served;

endmodule

// File: tb/tb_nibble_src_arbiter.sv
module tb_nibble_src_arbiter;

    localparam int N_REQ = 4;
    localparam int CNT_W = 8;

    logic                   sclk;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic                   ask_for_data;
    logic [3:0]             data;
    logic [N_REQ-1:0]       gnt;
    logic [3:0]             dout;
    logic [N_REQ-1:0]       dout_vld;
    logic                   busy;
    logic [N_REQ*CNT_W-1:0] served_cnt;

    logic [3:0] src;
    logic [3:0] noise;

    int total;
    int bad;

    nibble_src_arbiter #(
        .N_REQ   (N_REQ),
        .CAP_DLY (1),
        .CNT_W   (CNT_W)
    ) dut (
        .sclk         (sclk),
        .rst          (rst),
        .req          (req),
        .ask_for_data (ask_for_data),
        .data         (data),
        .gnt          (gnt),
        .dout         (dout),
        .dout_vld     (dout_vld),
        .busy         (busy),
        .served_cnt   (served_cnt)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Nibble source model: counts up once per ask pulse, cleared by reset.
    always @(posedge sclk or negedge rst) begin
        if (!rst) src <= 4'h0;
        else if (ask_for_data) src <= src + 4'h1;
    end
    assign data = src ^ noise;

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_gnt;
        logic [3:0] exp_dout;
        logic       rst_first;
        int         srv_idx;
        int         srv_exp;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [CNT_W-1:0] served_of(input int i);
        return served_cnt[i*CNT_W +: CNT_W];
    endfunction

    task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] act=%0h exp=%0h at %0t", name, tag, act, exp, $time);
        end
    endtask

    task automatic chk_all_clear(input int tag);
        chk("clr_ask",  tag, 32'(ask_for_data), 32'd0);
        chk("clr_gnt",  tag, 32'(gnt),          32'd0);
        chk("clr_vld",  tag, 32'(dout_vld),     32'd0);
        chk("clr_busy", tag, 32'(busy),         32'd0);
        chk("clr_dout", tag, 32'(dout),         32'd0);
        chk("clr_srv",  tag, served_cnt,        32'd0);
    endtask

    // One full transaction; the next posedge must be the sampling edge.
    task automatic run_txn(input logic [3:0] eg, input logic [3:0] ed, input int tag);
        @(posedge sclk); #1;
        chk("ask_hi",   tag, 32'(ask_for_data), 32'd1);
        chk("ask_gnt",  tag, 32'(gnt),          32'(eg));
        chk("ask_busy", tag, 32'(busy),         32'd1);
        chk("ask_vld",  tag, 32'(dout_vld),     32'd0);
        @(posedge sclk); #1;
        chk("wait_ask", tag, 32'(ask_for_data), 32'd0);
        chk("wait_gnt", tag, 32'(gnt),          32'(eg));
        @(posedge sclk); #1;
        chk("done_vld",  tag, 32'(dout_vld), 32'(eg));
        chk("done_dout", tag, 32'(dout),     32'(ed));
        chk("done_gnt",  tag, 32'(gnt),      32'(eg));
        @(posedge sclk); #1;
        chk("idle_busy", tag, 32'(busy),         32'd0);
        chk("idle_gnt",  tag, 32'(gnt),          32'd0);
        chk("idle_vld",  tag, 32'(dout_vld),     32'd0);
        chk("idle_ask",  tag, 32'(ask_for_data), 32'd0);
    endtask

    initial begin
        logic [3:0] nib;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        req   = '0;
        noise = '0;

        vecs[0]  = '{4'b0001, 4'b0001, 4'h1, 1'b0, -1, 0};
        vecs[1]  = '{4'b0001, 4'b0001, 4'h2, 1'b0, -1, 0};
        vecs[2]  = '{4'b0001, 4'b0001, 4'h3, 1'b0, -1, 0};
        vecs[3]  = '{4'b0001, 4'b0001, 4'h4, 1'b0, -1, 0};
        vecs[4]  = '{4'b0001, 4'b0001, 4'h5, 1'b0,  0, 5};
        vecs[5]  = '{4'b1111, 4'b0001, 4'h1, 1'b1, -1, 0};
        vecs[6]  = '{4'b1111, 4'b0010, 4'h2, 1'b0, -1, 0};
        vecs[7]  = '{4'b1111, 4'b0100, 4'h3, 1'b0, -1, 0};
        vecs[8]  = '{4'b1111, 4'b1000, 4'h4, 1'b0, -1, 0};
        vecs[9]  = '{4'b1111, 4'b0001, 4'h5, 1'b0,  0, 2};
        vecs[10] = '{4'b1010, 4'b0010, 4'h6, 1'b0, -1, 0};
        vecs[11] = '{4'b1010, 4'b1000, 4'h7, 1'b0, -1, 0};
        vecs[12] = '{4'b1010, 4'b0010, 4'h8, 1'b0,  1, 3};
        vecs[13] = '{4'b1010, 4'b1000, 4'h9, 1'b0,  3, 3};

        repeat (3) @(posedge sclk);
        #1;
        chk_all_clear(0);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            req = vecs[i].req;
            if (vecs[i].rst_first) begin
                #2 rst = 1'b0;
                #5;
                chk_all_clear(100 + i);
                #5 rst = 1'b1;
                #1;
                chk("post_rst_ask", i, 32'(ask_for_data), 32'd0);
                chk("post_rst_busy", i, 32'(busy), 32'd0);
            end
            run_txn(vecs[i].exp_gnt, vecs[i].exp_dout, i);
            if (vecs[i].srv_idx >= 0)
                chk("served", i, 32'(served_of(vecs[i].srv_idx)), 32'(vecs[i].srv_exp));
        end

        // Request dropped during WAIT still completes; no further asks.
        req = 4'b0100;
        @(posedge sclk); #1;
        chk("drop_gnt", 0, 32'(gnt), 32'b0100);
        @(posedge sclk); #1;
        req = '0;
        @(posedge sclk); #1;
        chk("drop_vld",  0, 32'(dout_vld), 32'b0100);
        chk("drop_dout", 0, 32'(dout),     32'hA);
        @(posedge sclk); #1;
        chk("drop_srv", 0, 32'(served_of(2)), 32'd2);
        for (int c = 0; c < 4; c++) begin
            noise = 4'(c * 5 + 3);
            @(posedge sclk); #1;
            chk("drop_idle_ask",  c, 32'(ask_for_data), 32'd0);
            chk("drop_idle_busy", c, 32'(busy),         32'd0);
            chk("hold_dout",      c, 32'(dout),         32'hA);
        end
        noise = '0;

        // Reset in WAIT aborts; pointer returns to 0.
        req = 4'b1000;
        @(posedge sclk); #1;
        chk("abort_gnt", 0, 32'(gnt), 32'b1000);
        @(posedge sclk); #1;
        #2 rst = 1'b0;
        #1;
        chk_all_clear(200);
        req = 4'b1111;
        #9 rst = 1'b1;
        run_txn(4'b0001, 4'h1, 300);
        chk("abort_srv3", 0, 32'(served_of(3)), 32'd0);
        chk("abort_srv0", 0, 32'(served_of(0)), 32'd1);

        // Single requester held continuously; counter wraps at 256.
        req = 4'b0010;
        nib = 4'h2;
        for (int t = 0; t < 256; t++) begin
            run_txn(4'b0010, nib, 400 + t);
            nib = nib + 4'h1;
            if (t == 254) chk("wrap_pre", t, 32'(served_of(1)), 32'd255);
        end
        chk("wrap_post", 0, 32'(served_of(1)), 32'd0);
        req = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
